// File: rtl/pea_cmd_writer.sv
// Host-side producer for the polynomial evaluation actor: packs a request,
// streams its operand tokens into the data FIFO, then writes the command word.
module pea_cmd_writer #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_cmd,
  input  logic [7:0]           instr_in,
  input  logic [2:0]           arg1_in,
  input  logic [4:0]           arg2_in,
  input  logic [word_size-1:0] tok_in,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic [word_size-1:0] pop_in_fifo_data,
  input  logic [word_size-1:0] pop_in_fifo_command,
  output logic                 wr_fifo_data,
  output logic [word_size-1:0] data_out_data,
  output logic                 wr_fifo_command,
  output logic [word_size-1:0] data_out_command,
  output logic                 busy,
  output logic                 done_cmd,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE, DECODE, WAIT_SPACE, DATA, CMD, DONE
  } state_t;

  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_RST = 8'd3;

  localparam int CW = word_size + 1;
  localparam logic [CW-1:0] BUF_W = CW'(buffer_size);

  state_t state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [2:0] arg1_q, arg1_d;
  logic [4:0] arg2_q, arg2_d;
  logic [5:0] cnt_q, cnt_d;
  logic wr_data_q, wr_data_d;
  logic [word_size-1:0] dout_data_q, dout_data_d;
  logic [word_size-1:0] dout_cmd_q, dout_cmd_d;
  logic err_q, err_d;

  logic [15:0] cmd_word;
  logic [CW-1:0] need;
  logic space_ok;
  logic accept;

  assign cmd_word = {arg2_q, arg1_q, instr_q};
  // Whole operand block is reserved before the first token goes out
  assign need = {1'b0, pop_in_fifo_data} + CW'(cnt_q);
  assign space_ok = (need <= BUF_W) &&
                    ({1'b0, pop_in_fifo_command} < BUF_W);
  assign accept = (state_q == DATA) && tok_valid;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    cnt_d       = cnt_q;
    wr_data_d   = 1'b0;
    dout_data_d = dout_data_q;
    dout_cmd_d  = dout_cmd_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_cmd) begin
          instr_d = instr_in;
          arg1_d  = arg1_in;
          arg2_d  = arg2_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = WAIT_SPACE;
        unique case (1'b1)
          (instr_q == OP_STP): cnt_d = {1'b0, arg2_q} + 6'd1;
          (instr_q == OP_EVP): cnt_d = 6'd1;
          (instr_q == OP_EVB): cnt_d = {1'b0, arg2_q};
          (instr_q == OP_RST): cnt_d = 6'd0;
          default: begin
            cnt_d   = 6'd0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          state_d = (cnt_q != 6'd0) ? DATA : CMD;
        end
      end
      DATA: begin
        if (accept) begin
          wr_data_d   = 1'b1;
          dout_data_d = tok_in;
          cnt_d       = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = CMD;
          end
        end
      end
      CMD:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == CMD) begin
      dout_cmd_d = word_size'(cmd_word);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      arg1_q      <= '0;
      arg2_q      <= '0;
      cnt_q       <= '0;
      wr_data_q   <= 1'b0;
      dout_data_q <= '0;
      dout_cmd_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      arg1_q      <= arg1_d;
      arg2_q      <= arg2_d;
      cnt_q       <= cnt_d;
      wr_data_q   <= wr_data_d;
      dout_data_q <= dout_data_d;
      dout_cmd_q  <= dout_cmd_d;
      err_q       <= err_d;
    end
  end

  assign tok_ready        = (state_q == DATA);
  assign wr_fifo_data     = wr_data_q;
  assign data_out_data    = dout_data_q;
  assign wr_fifo_command  = (state_q == CMD);
  assign data_out_command = dout_cmd_q;
  assign busy             = (state_q != IDLE);
  assign done_cmd         = (state_q == DONE);
  assign err              = err_q;

endmodule

// File: tb/tb_pea_cmd_writer.sv
// Directed bench for pea_cmd_writer: expected FIFO words are queued when a
// request is issued and popped as the block writes them.
module tb_pea_cmd_writer;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         start_cmd = 1'b0;
  logic [7:0]   instr_in = '0;
  logic [2:0]   arg1_in = '0;
  logic [4:0]   arg2_in = '0;
  logic [W-1:0] tok_in = '0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [W-1:0] pop_in_fifo_data = '0;
  logic [W-1:0] pop_in_fifo_command = '0;
  logic         wr_fifo_data;
  logic [W-1:0] data_out_data;
  logic         wr_fifo_command;
  logic [W-1:0] data_out_command;
  logic         busy;
  logic         done_cmd;
  logic         err;

  pea_cmd_writer #(.word_size(W), .buffer_size(1024)) dut (
    .clk(clk),
    .rst(rst),
    .start_cmd(start_cmd),
    .instr_in(instr_in),
    .arg1_in(arg1_in),
    .arg2_in(arg2_in),
    .tok_in(tok_in),
    .tok_valid(tok_valid),
    .tok_ready(tok_ready),
    .pop_in_fifo_data(pop_in_fifo_data),
    .pop_in_fifo_command(pop_in_fifo_command),
    .wr_fifo_data(wr_fifo_data),
    .data_out_data(data_out_data),
    .wr_fifo_command(wr_fifo_command),
    .data_out_command(data_out_command),
    .busy(busy),
    .done_cmd(done_cmd),
    .err(err)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] dq[$];
  logic [W-1:0] cq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (wr_fifo_data) begin
        if (dq.size() == 0) chk("data_unexpected", 1, 0);
        else chk("data_word", data_out_data, dq.pop_front());
      end
      if (wr_fifo_command) begin
        if (cq.size() == 0) chk("cmd_unexpected", 1, 0);
        else chk("cmd_word", data_out_command, cq.pop_front());
      end
      if (done_cmd) done_cnt++;
      if (err) err_cnt++;
      if (!busy) chk("tok_ready_idle", tok_ready, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] i, input logic [2:0] a,
                       input logic [4:0] b);
    instr_in  = i;
    arg1_in   = a;
    arg2_in   = b;
    start_cmd = 1'b1;
    tick();
    start_cmd = 1'b0;
  endtask

  task automatic send_tok(input logic [W-1:0] v);
    bit ok;
    ok = 1'b0;
    tok_in = v;
    tok_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("tok_timeout", 0, 1);
    tick();
    tok_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (done_cmd) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctl", {tok_ready, wr_fifo_data, wr_fifo_command,
                      busy, done_cmd, err}, 0);
    chk("reset_dd", data_out_data, 0);
    chk("reset_dc", data_out_command, 0);
    tick();
    rst = 1'b1;
    tick();

    // RST: command only, fixed latency
    cq.push_back(16'h0003);
    start(8'd3, 3'd0, 5'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_wrcmd_c%0d", c), wr_fifo_command, (c == 3));
      chk($sformatf("rst_done_c%0d", c), done_cmd, (c == 4));
    end
    tick();

    // EVP: one token ready immediately
    dq.push_back(16'h0005);
    cq.push_back(16'h0101);
    tok_in = 16'h0005;
    tok_valid = 1'b1;
    start(8'd1, 3'd1, 5'd0);
    wait_done(20);
    tok_valid = 1'b0;
    tick();

    // STP N=3 with tok_valid gaps
    for (int i = 1; i <= 4; i++) dq.push_back(W'(i));
    cq.push_back(16'h1A00);
    start(8'd0, 3'd2, 5'd3);
    for (int i = 1; i <= 4; i++) begin
      send_tok(W'(i));
      tick();
    end
    wait_done(20);
    tick();

    // Backpressure: 2 slots free, 4 needed
    pop_in_fifo_data = 16'd1022;
    for (int i = 0; i < 4; i++) dq.push_back(W'(16'h0010 + i));
    cq.push_back(16'h1B00);
    start(8'd0, 3'd3, 5'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", {busy, tok_ready, wr_fifo_data, wr_fifo_command},
          4'b1000);
    end
    pop_in_fifo_data = 16'd1020;
    for (int i = 0; i < 4; i++) send_tok(W'(16'h0010 + i));
    wait_done(20);
    pop_in_fifo_data = '0;
    tick();

    // Illegal opcode, plus a start while busy that must be ignored
    instr_in = 8'd5;
    start_cmd = 1'b1;
    tick();
    instr_in = 8'd3;
    tick();
    start_cmd = 1'b0;
    @(negedge clk);
    chk("illegal_err", err, 1);
    chk("illegal_idle", busy, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("illegal_quiet", {busy, err, done_cmd}, 0);
    end
    chk("err_count", err_cnt, 1);
    tick();

    // EVB b=0: command only
    cq.push_back(16'h0102);
    start(8'd2, 3'd1, 5'd0);
    wait_done(20);
    tick();

    // Reset in the middle of an EVB transfer
    dq.push_back(16'hAAAA);
    start(8'd2, 3'd0, 5'd2);
    send_tok(16'hAAAA);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_ctl", {tok_ready, wr_fifo_data, wr_fifo_command,
                       busy, done_cmd, err}, 0);
    chk("midrst_dd", data_out_data, 0);
    chk("midrst_dc", data_out_command, 0);
    #1;
    rst = 1'b1;
    repeat (5) tick();

    dq.push_back(16'hB001);
    dq.push_back(16'hB002);
    cq.push_back(16'h1002);
    start(8'd2, 3'd0, 5'd2);
    send_tok(16'hB001);
    send_tok(16'hB002);
    wait_done(20);
    repeat (3) tick();

    chk("data_q_empty", dq.size(), 0);
    chk("cmd_q_empty", cq.size(), 0);
    chk("done_count", done_cnt, 6);
    chk("err_total", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
